// File: rtl/mem_pkg.sv
// Shared types and helpers for the two-write/two-read word memory.
// Used by mem_clear_seq and mem_2w2r.
package mem_pkg;

    typedef enum logic {CLEAR, READY} mem_state_t;

    // Widest word byte_merge handles; callers zero-extend and truncate.
    localparam int MAX_WIDTH = 512;

    typedef logic [MAX_WIDTH-1:0]   max_word_t;
    typedef logic [MAX_WIDTH/8-1:0] max_strb_t;

    function automatic int lsb_of(input int width);
        return $clog2(width / 8);
    endfunction

    function automatic int aw_of(input int depth);
        return $clog2(depth);
    endfunction

    function automatic max_word_t byte_merge(input max_word_t old_word,
                                             input max_word_t data,
                                             input max_strb_t strobe);
        max_word_t merged;
        merged = old_word;
        for (int i = 0; i < MAX_WIDTH / 8; i++) begin
            if (strobe[i]) merged[8*i +: 8] = data[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/mem_2w2r_if.sv
// Request/response bundle of mem_2w2r: two write ports, two read ports, busy.
// master = requester (core), slave = memory.
interface mem_2w2r_if #(parameter int WIDTH = 32);

    logic               wen1;
    logic [WIDTH-1:0]   addrw1;
    logic [WIDTH-1:0]   dataw1;
    logic [WIDTH/8-1:0] wstrb1;
    logic               wen2;
    logic [WIDTH-1:0]   addrw2;
    logic [WIDTH-1:0]   dataw2;
    logic [WIDTH/8-1:0] wstrb2;
    logic               rena;
    logic [WIDTH-1:0]   addra;
    logic               renb;
    logic [WIDTH-1:0]   addrb;
    logic [WIDTH-1:0]   outa;
    logic [WIDTH-1:0]   outb;
    logic               valida;
    logic               validb;
    logic               busy;

    modport master (
        output wen1, addrw1, dataw1, wstrb1,
        output wen2, addrw2, dataw2, wstrb2,
        output rena, addra, renb, addrb,
        input  outa, outb, valida, validb, busy
    );

    modport slave (
        input  wen1, addrw1, dataw1, wstrb1,
        input  wen2, addrw2, dataw2, wstrb2,
        input  rena, addra, renb, addrb,
        output outa, outb, valida, validb, busy
    );

endinterface

// File: rtl/mem_clear_seq.sv
// Post-reset clear sequencer: walks every word once writing zero, then
// reports READY. busy is high for exactly DEPTH edges after reset release.
module mem_clear_seq
    import mem_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     busy,
    output logic                     clr_we,
    output logic [aw_of(DEPTH)-1:0]  clr_idx
);

    localparam int AW = aw_of(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    mem_state_t    state, next_state;
    logic [AW-1:0] cnt, next_cnt;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // NOTE: every output gets a default first so no path infers a latch.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        busy       = 1'b0;
        clr_we     = 1'b0;
        clr_idx    = cnt;
        case (state)
            CLEAR: begin
                busy     = 1'b1;
                clr_we   = 1'b1;
                next_cnt = cnt + 1'b1;
                if (cnt == LAST) next_state = READY;
            end
            READY:   ;
            default: next_state = CLEAR;
        endcase
    end

endmodule

// File: rtl/mem_2w2r.sv
// Two-write/two-read word memory with byte strobes, registered reads and a
// post-reset clear. Define MEM_BYPASS_EN for write-first reads (default read-first).
module mem_2w2r
    import mem_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024
) (
    input  logic            clk,
    input  logic            rst,
    mem_2w2r_if.slave       bus
);

    localparam int LSB = lsb_of(WIDTH);
    localparam int AW  = aw_of(DEPTH);

    typedef logic [WIDTH-1:0]   word_t;
    typedef logic [WIDTH/8-1:0] strb_t;
    typedef logic [AW-1:0]      idx_t;

    function automatic word_t merge(input word_t old_word, input word_t data, input strb_t strobe);
        max_word_t r;
        r = byte_merge(max_word_t'(old_word), max_word_t'(data), max_strb_t'(strobe));
        return r[WIDTH-1:0];
    endfunction

    logic  busy, clr_we;
    idx_t  clr_idx;

    mem_clear_seq #(.DEPTH(DEPTH)) u_clear (
        .clk     (clk),
        .rst     (rst),
        .busy    (busy),
        .clr_we  (clr_we),
        .clr_idx (clr_idx)
    );

    word_t mem [DEPTH];

    idx_t widx1, widx2, ridx_a, ridx_b;
    assign widx1  = bus.addrw1[LSB +: AW];
    assign widx2  = bus.addrw2[LSB +: AW];
    assign ridx_a = bus.addra[LSB +: AW];
    assign ridx_b = bus.addrb[LSB +: AW];

    // Byte offset and wrap bits of the addresses are intentionally ignored.
    logic addr_unused;
    assign addr_unused = ^{bus.addrw1, bus.addrw2, bus.addra, bus.addrb};

    logic we1, we2, rd_a, rd_b;
    assign we1  = bus.wen1 && !busy;
    assign we2  = bus.wen2 && !busy;
    assign rd_a = bus.rena && !busy;
    assign rd_b = bus.renb && !busy;

    // m1 and m2 are identical when both ports hit one word, so the double write is safe.
    word_t m1, m2;
    always_comb begin
        m1 = merge(mem[widx1], bus.dataw1, bus.wstrb1);
        if (we2 && widx2 == widx1) m1 = merge(m1, bus.dataw2, bus.wstrb2);
        if (we1 && widx1 == widx2) m2 = m1;
        else                       m2 = merge(mem[widx2], bus.dataw2, bus.wstrb2);
    end

    // NOTE: the array has no reset; the clear sequencer zeroes it instead.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_idx] <= '0;
        end else begin
            if (we1) mem[widx1] <= m1;
            if (we2) mem[widx2] <= m2;
        end
    end

    word_t rdata_a, rdata_b;
`ifdef MEM_BYPASS_EN
    assign rdata_a = (we1 && widx1 == ridx_a) ? m1 :
                     (we2 && widx2 == ridx_a) ? m2 : mem[ridx_a];
    assign rdata_b = (we1 && widx1 == ridx_b) ? m1 :
                     (we2 && widx2 == ridx_b) ? m2 : mem[ridx_b];
`else
    assign rdata_a = mem[ridx_a];
    assign rdata_b = mem[ridx_b];
`endif

    word_t outa_q, outb_q;
    logic  valida_q, validb_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outa_q   <= '0;
            outb_q   <= '0;
            valida_q <= 1'b0;
            validb_q <= 1'b0;
        end else begin
            valida_q <= rd_a;
            validb_q <= rd_b;
            if (rd_a) outa_q <= rdata_a;
            if (rd_b) outb_q <= rdata_b;
        end
    end

    assign bus.outa   = outa_q;
    assign bus.outb   = outb_q;
    assign bus.valida = valida_q;
    assign bus.validb = validb_q;
    assign bus.busy   = busy;

endmodule

// File: tb/tb_mem_2w2r.sv
// Scoreboard bench for mem_2w2r (WIDTH=32, DEPTH=16): reads push expected words,
// a negedge monitor pops and compares on every valid pulse.
module tb_mem_2w2r;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
`ifdef MEM_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_2w2r_if #(.WIDTH(WIDTH)) bus ();

    mem_2w2r #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_a[$];
    logic [31:0] exp_b[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.valida === 1'b1) begin
            if (exp_a.size() == 0) check("valida spurious", {31'b0, bus.valida}, 32'd0);
            else                   check("outa", bus.outa, exp_a.pop_front());
        end
        if (bus.validb === 1'b1) begin
            if (exp_b.size() == 0) check("validb spurious", {31'b0, bus.validb}, 32'd0);
            else                   check("outb", bus.outb, exp_b.pop_front());
        end
    end

    task automatic idle();
        bus.wen1 = 1'b0; bus.addrw1 = '0; bus.dataw1 = '0; bus.wstrb1 = '0;
        bus.wen2 = 1'b0; bus.addrw2 = '0; bus.dataw2 = '0; bus.wstrb2 = '0;
        bus.rena = 1'b0; bus.addra  = '0;
        bus.renb = 1'b0; bus.addrb  = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr1(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bus.wen1 = 1'b1; bus.addrw1 = a; bus.dataw1 = d; bus.wstrb1 = s;
    endtask

    task automatic wr2(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bus.wen2 = 1'b1; bus.addrw2 = a; bus.dataw2 = d; bus.wstrb2 = s;
    endtask

    task automatic rda(input logic [31:0] a, input logic [31:0] e);
        bus.rena = 1'b1; bus.addra = a; exp_a.push_back(e);
    endtask

    task automatic rdb(input logic [31:0] a, input logic [31:0] e);
        bus.renb = 1'b1; bus.addrb = a; exp_b.push_back(e);
    endtask

    // Requests held during the clear must be dropped (monitor flags any valid).
    task automatic wait_clear(input string name);
        int cycles;
        cycles = 0;
        bus.rena = 1'b1; bus.addra = 32'h8;
        bus.wen1 = 1'b1; bus.addrw1 = 32'h8; bus.dataw1 = 32'hFFFF_FFFF; bus.wstrb1 = 4'hF;
        while (bus.busy === 1'b1 && cycles < 64) begin
            tick();
            cycles++;
        end
        idle();
        check(name, cycles, DEPTH);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " outa"},   bus.outa, 32'h0);
        check({tag, " outb"},   bus.outb, 32'h0);
        check({tag, " valida"}, {31'b0, bus.valida}, 32'd0);
        check({tag, " validb"}, {31'b0, bus.validb}, 32'd0);
        check({tag, " busy"},   {31'b0, bus.busy},   32'd1);
    endtask

    initial begin
        idle();
        #12;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b1;
        wait_clear("busy cycles after reset");

        // Every word reads zero after the clear, back-to-back on both ports.
        for (int i = 0; i < DEPTH; i++) begin
            rda(32'(i * 4), 32'h0);
            rdb(32'(i * 4 + 2), 32'h0);
            tick();
        end
        idle();
        tick();

        // Partial-strobe overwrite, then outa must hold with valida low.
        wr1(32'h08, 32'hDEAD_BEEF, 4'hF); tick();
        wr1(32'h08, 32'h0000_00AA, 4'h1); tick();
        idle(); wr1(32'h08, 32'h1234_5678, 4'h0); rda(32'h08, 32'hDEAD_BEAA); tick();
        idle(); tick();
        check("hold outa", bus.outa, 32'hDEAD_BEAA);
        check("hold valida", {31'b0, bus.valida}, 32'd0);

        // Same-word dual write: port 2 wins on overlapping strobes.
        wr1(32'h04, 32'h1111_1111, 4'hF); wr2(32'h04, 32'h2222_2222, 4'hC); tick();
        idle(); rda(32'h04, 32'h2222_1111); tick();
        idle();

        // Same-edge read of a word being written.
        wr1(32'h0C, 32'hCAFE_F00D, 4'hF);
        rda(32'h0C, BYP ? 32'hCAFE_F00D : 32'h0); tick();
        idle(); rda(32'h0C, 32'hCAFE_F00D); tick();
        idle();

        // Same-edge read of a dual-port merged write.
        wr1(32'h14, 32'h1234_5678, 4'h3); wr2(32'h14, 32'hAABB_CCDD, 4'h6);
        rdb(32'h14, BYP ? 32'h00BB_CC78 : 32'h0); tick();
        idle(); rdb(32'h17, 32'h00BB_CC78); tick();
        idle();

        // Address wrap: 0x44 lands on word 1, read via two aliases.
        wr2(32'h44, 32'h5A5A_A5A5, 4'hF); tick();
        idle(); rda(32'h04, 32'h5A5A_A5A5); rdb(32'h07, 32'h5A5A_A5A5); tick();
        idle(); tick();

        // Reset during a read: outputs drop at once and the clear restarts.
        wr1(32'h0C, 32'h0BAD_F00D, 4'hF); tick();
        idle(); bus.rena = 1'b1; bus.addra = 32'h0C; tick();
        check("pre-reset outa", bus.outa, 32'h0BAD_F00D);
        check("pre-reset valida", {31'b0, bus.valida}, 32'd1);
        idle();
        #1 rst = 1'b0;
        #1 check_reset_outputs("mid reset");
        @(posedge clk); #1;
        rst = 1'b1;
        wait_clear("busy cycles after re-reset");
        rda(32'h0C, 32'h0); rdb(32'h08, 32'h0); tick();
        idle(); rda(32'h04, 32'h0); rdb(32'h14, 32'h0); tick();
        idle();

        for (int i = 0; i < 4; i++) tick();
        check("port A results outstanding", exp_a.size(), 32'd0);
        check("port B results outstanding", exp_b.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
